// File: rtl/uartUtil.sv
// Shared UART definitions used by the transmitter and the receiver.
//   states_t              : frame-level FSM states (IDLE, START, SEND, STOP)
//   DEFAULT_CLKS_PER_BIT  : default bit period in clock cycles
//   timer_width()         : width of a counter that spans 0..clks-1 (at least 1 bit)
package uartUtil;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2,
        STOP  = 2'd3
    } states_t;

    localparam int DEFAULT_CLKS_PER_BIT = 1;

    function automatic int timer_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/transmitter.sv
// UART transmitter: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1),
// each bit held for CLKS_PER_BIT clock cycles. Valid/ready byte handshake.
// Ports:
//   clk               in   sole clock, rising edge
//   rst               in   synchronous active-high reset
//   byteToSend [7:0]  in   byte sampled on an accepted handshake
//   sendValid         in   requester offers a byte
//   sendReady         out  transmitter accepts a byte this cycle
//   transmitterOutput out  serial line, idle high
//   done              out  high while the stop bit is driven
module transmitter
    import uartUtil::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byteToSend,
    input  logic       sendValid,
    output logic       sendReady,
    output logic       transmitterOutput,
    output logic       done
);

    localparam int            TW   = timer_width(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    states_t       state;
    states_t       state_n;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_n;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_n;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_n;
    logic          line_n;
    logic          done_n;
    logic          ready_n;
    logic          accept;
    logic          wrap;

    // sendReady is a register, so the handshake depends on no combinational input path
    assign accept = sendValid && sendReady;
    assign wrap   = (timer == LAST);

    // Next-state, datapath and next-output computation
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        bit_cnt_n = bit_cnt;
        shift_n   = shift_reg;
        case (state)
            IDLE: begin
                timer_n   = '0;
                bit_cnt_n = 3'd0;
                if (accept) begin
                    state_n = START;
                    shift_n = byteToSend;
                end else begin
                    state_n = IDLE;
                end
            end
            START: begin
                if (wrap) begin
                    timer_n   = '0;
                    bit_cnt_n = 3'd0;
                    state_n   = SEND;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            SEND: begin
                if (wrap) begin
                    timer_n = '0;
                    shift_n = {1'b0, shift_reg[7:1]};
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_n = 3'd0;
                        state_n   = STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            STOP: begin
                if (wrap) begin
                    timer_n = '0;
                    // a handshake on the last stop cycle chains straight into the next frame
                    if (accept) begin
                        state_n = START;
                        shift_n = byteToSend;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            default: begin
                state_n   = IDLE;
                timer_n   = '0;
                bit_cnt_n = 3'd0;
                shift_n   = 8'h00;
            end
        endcase

        // Outputs are registered: derive them from the values the state will take next
        case (state_n)
            START:   line_n = 1'b0;
            SEND:    line_n = shift_n[0];
            default: line_n = 1'b1;
        endcase
        done_n  = (state_n == STOP);
        ready_n = (state_n == IDLE) || ((state_n == STOP) && (timer_n == LAST));
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            timer             <= '0;
            bit_cnt           <= 3'd0;
            shift_reg         <= 8'h00;
            transmitterOutput <= 1'b1;
            sendReady         <= 1'b1;
            done              <= 1'b0;
        end else begin
            state             <= state_n;
            timer             <= timer_n;
            bit_cnt           <= bit_cnt_n;
            shift_reg         <= shift_n;
            transmitterOutput <= line_n;
            sendReady         <= ready_n;
            done              <= done_n;
        end
    end

endmodule

// File: doc/transmitter.md
TRANSMITTER -- requirements
Module: transmitter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1, clock cycles per serial bit; SHALL be >= 1.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 byteToSend  input  8  data byte, sampled only on an accepted handshake.
REQ-005 sendValid  input  1  requester has a byte on byteToSend.
REQ-006 sendReady  output  1  transmitter can accept a byte this cycle.
REQ-007 transmitterOutput  output  1  serial line; idle-high.
REQ-008 done  output  1  high while the stop bit is driven.

Function
REQ-009 The FSM SHALL use states IDLE, START, SEND, STOP; any illegal state SHALL go to IDLE next cycle.
REQ-010 A byte SHALL be accepted on a rising edge where sendValid && sendReady; accepted byte latched into an internal shift register.
REQ-011 sendReady SHALL be 1 in IDLE and on the final cycle of STOP, and 0 otherwise.
REQ-012 sendValid SHALL be ignored while sendReady is 0; changes to byteToSend after acceptance SHALL NOT affect the frame in flight.
REQ-013 Acceptance at edge k SHALL put the FSM in START with transmitterOutput=0 from cycle k+1 (latency 1 cycle).
REQ-014 Frame: START 0 for CLKS_PER_BIT cycles; SEND 8 data bits, LSB first, each for CLKS_PER_BIT cycles; STOP 1 for CLKS_PER_BIT cycles; total 10*CLKS_PER_BIT cycles.
REQ-015 transmitterOutput SHALL be 1 in IDLE and STOP, 0 in START, shiftReg[0] in SEND, derived only from registers (no combinational path from any input).
REQ-016 A bit timer SHALL count 0..CLKS_PER_BIT-1 and wrap; state/bit advances happen only on timer wrap; timer width max(1, ceil(log2 CLKS_PER_BIT)).
REQ-017 A bit counter SHALL count 0..7 in SEND; shift register shifts right one place per completed data bit; SEND->STOP after bit 7 completes.
REQ-018 STOP->START (no idle gap) when a handshake occurs on STOP's final cycle; otherwise STOP->IDLE.
REQ-019 done SHALL equal (state == STOP); with CLKS_PER_BIT=1 it is a one-cycle pulse per frame.
REQ-020 With CLKS_PER_BIT=1, output SHALL be bit-exact decodable by the team receiver (receiver START samples data bit 0).

Reset
REQ-021 rst high at an edge SHALL force next cycle: state IDLE, transmitterOutput=1, sendReady=1, done=0, shift register 8'h00, bit timer 0, bit counter 0.
REQ-022 rst SHALL override any simultaneous handshake; a frame in flight is aborted, never resumed.
REQ-023 Operation SHALL resume with the first handshake after rst deasserts.

Structure
REQ-024 State enum SHALL be uartUtil::states_t (IDLE, START, SEND, STOP), shared with the receiver; no new state type.
REQ-025 Default CLKS_PER_BIT value SHALL be a constant in uartUtil, shared by transmitter and receiver benches.
REQ-026 Single module, no sub-module; bit timer inline; a uartLoopback top (transmitter + receiver) exists only in verification.

Verification
REQ-027 Reset: hold rst 2 cycles, sendValid=1 -> transmitterOutput=1, sendReady=1, done=0; no frame starts until rst=0.
REQ-028 CLKS_PER_BIT=1, send 8'hA5 -> line from k+1: 0,1,0,1,0,0,1,0,1,1; done=1 only on the stop-bit cycle; sendReady=1 on that cycle.
REQ-029 Back-to-back: sendValid held, 8'h00 then 8'hFF -> 20 contiguous cycles 0,00000000,1,0,11111111,1, no idle cycle between frames.
REQ-030 Loopback with receiver, CLKS_PER_BIT=1, send 8'h3C -> receiver byteRecieved=8'h3C and receiver done asserted once.
REQ-031 rst for 1 cycle during data bit 4 of 8'hF0 -> line 1 next cycle, state IDLE; following 8'h81 transmits correctly.
REQ-032 CLKS_PER_BIT=4, send 8'h01, offer 8'h55 mid-frame -> each level held 4 cycles, 40-cycle frame; 8'h55 accepted only on the final STOP cycle.
